// File: rtl/gpr_port_ctrl.sv
// gpr_port_ctrl: scoreboarded operand fetch for the GPR file plus a two-producer writeback FIFO feeding its single write port.
module gpr_port_ctrl #(
    parameter int XLEN      = 32,
    parameter int WBQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_we,
    output logic            opnd_valid,
    input  logic            opnd_ready,
    output logic [XLEN-1:0] opnd_a,
    output logic [XLEN-1:0] opnd_b,
    output logic [4:0]      opnd_rd,
    input  logic            wb0_valid,
    output logic            wb0_ready,
    input  logic [4:0]      wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_valid,
    output logic            wb1_ready,
    input  logic [4:0]      wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    output logic            rf_write_en,
    output logic [4:0]      rf_write_dest,
    output logic [XLEN-1:0] rf_write_data,
    output logic [4:0]      rf_read_addr_1,
    output logic [4:0]      rf_read_addr_2,
    input  logic [XLEN-1:0] rf_read_data_1,
    input  logic [XLEN-1:0] rf_read_data_2,
    output logic [31:0]     busy_mask
);
    localparam int AW = $clog2(WBQ_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, CHECK, OUT} state_t;
    state_t          r_state, w_next;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic            r_rd_we;
    logic [XLEN-1:0] r_opnd_a, r_opnd_b;
    logic [4:0]      r_opnd_rd;
    logic [31:0]     r_pending, w_pending_nxt;
    logic [4:0]      r_q_rd   [WBQ_DEPTH];
    logic [XLEN-1:0] r_q_data [WBQ_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_wr1;
    logic [CW-1:0]   r_count, w_free;
    logic            w_hazard, w_go, w_set, w_accept;
    logic            w_push0, w_push1, w_pop;

    assign issue_ready    = r_state == IDLE;
    assign opnd_valid     = r_state == OUT;
    assign opnd_a         = r_opnd_a;
    assign opnd_b         = r_opnd_b;
    assign opnd_rd        = r_opnd_rd;
    assign rf_read_addr_1 = r_rs1;
    assign rf_read_addr_2 = r_rs2;
    assign busy_mask      = r_pending;
    assign w_accept = issue_ready && issue_valid;
    assign w_hazard = (r_rs1 != '0 && r_pending[r_rs1]) ||
                      (r_rs2 != '0 && r_pending[r_rs2]) ||
                      (r_rd_we && r_rd != '0 && r_pending[r_rd]);
    assign w_go     = r_state == CHECK && !w_hazard;
    assign w_set    = w_go && r_rd_we && r_rd != '0;
    // Free space ignores the same-cycle pop so ready never depends on the drain.
    assign w_free    = CW'(WBQ_DEPTH) - r_count;
    assign wb0_ready = w_free >= CW'(1);
    assign wb1_ready = w_free >= CW'(2);
    assign w_push0   = wb0_valid && wb0_ready && wb0_rd != '0;
    assign w_push1   = wb1_valid && wb1_ready && wb1_rd != '0;
    assign w_wr1     = r_wr_ptr + AW'(w_push0);
    assign w_pop         = r_count != '0;
    assign rf_write_en   = w_pop;
    assign rf_write_dest = r_q_rd[r_rd_ptr];
    assign rf_write_data = r_q_data[r_rd_ptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = issue_valid ? CHECK : IDLE;
            CHECK:   w_next = w_hazard ? CHECK : OUT;
            OUT:     w_next = opnd_ready ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    // Set is applied after clear so a same-edge collision leaves the bit set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) w_pending_nxt[rf_write_dest] = 1'b0;
        if (w_set) w_pending_nxt[r_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_opnd_a  <= '0;
            r_opnd_b  <= '0;
            r_opnd_rd <= '0;
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                r_rs1   <= issue_rs1;
                r_rs2   <= issue_rs2;
                r_rd    <= issue_rd;
                r_rd_we <= issue_rd_we;
            end
            if (w_go) begin
                r_opnd_a  <= r_rs1 == '0 ? '0 : rf_read_data_1;
                r_opnd_b  <= r_rs2 == '0 ? '0 : rf_read_data_2;
                r_opnd_rd <= r_rd;
            end
            r_pending <= w_pending_nxt;
            r_wr_ptr  <= w_wr1 + AW'(w_push1);
            r_rd_ptr  <= r_rd_ptr + AW'(w_pop);
            r_count   <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
        end

    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_q_rd[r_wr_ptr]   <= wb0_rd;
            r_q_data[r_wr_ptr] <= wb0_data;
        end
        if (w_push1) begin
            r_q_rd[w_wr1]   <= wb1_rd;
            r_q_data[w_wr1] <= wb1_data;
        end
    end
endmodule

// File: tb/tb_gpr_port_ctrl.sv
// tb_gpr_port_ctrl: directed vector and sequence checks of gpr_port_ctrl against a bench register-file model.
module tb_gpr_port_ctrl;
    logic        clk, rst;
    logic        issue_valid, issue_ready, issue_rd_we;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        opnd_valid, opnd_ready;
    logic [31:0] opnd_a, opnd_b;
    logic [4:0]  opnd_rd;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_dest, rf_read_addr_1, rf_read_addr_2;
    logic [31:0] rf_write_data, rf_read_data_1, rf_read_data_2, busy_mask;
    logic [31:0] rf_m [32];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] a, b, busy;
    } vec_t;
    vec_t vt [5];

    gpr_port_ctrl #(.XLEN(32), .WBQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_rd(opnd_rd),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest), .rf_write_data(rf_write_data),
        .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .busy_mask(busy_mask)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_m[i] <= 32'h1000_0000 + i;
            rf_m[3] <= 32'h22;
        end else if (rf_write_en) rf_m[rf_write_dest] <= rf_write_data;

    assign rf_read_data_1 = rf_m[rf_read_addr_1];
    assign rf_read_data_2 = rf_m[rf_read_addr_2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic we);
        int n = 0;
        while (!issue_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready_wait", {31'b0, issue_ready}, 32'd1);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_we = we;
        @(negedge clk);
        issue_valid = 0;
    endtask

    task automatic complete();
        chk("out_not_ready", {31'b0, issue_ready}, 32'd0);
        opnd_ready = 1;
        @(negedge clk);
        opnd_ready = 0;
        chk("back_idle", {31'b0, issue_ready}, 32'd1);
    endtask

    task automatic wb0_push(input logic [4:0] rd, input logic [31:0] data);
        wb0_valid = 1; wb0_rd = rd; wb0_data = data;
        @(negedge clk);
        wb0_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0; opnd_ready = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0; wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        rst = 0;
        vt[0] = '{rs1: 5'd1,  rs2: 5'd2, rd: 5'd10, we: 1'b1, a: 32'h1000_0001, b: 32'h1000_0002, busy: 32'h0000_0400};
        vt[1] = '{rs1: 5'd5,  rs2: 5'd4, rd: 5'd11, we: 1'b0, a: 32'hDEAD_BEEF,  b: 32'h0000_0044, busy: 32'h0000_0400};
        vt[2] = '{rs1: 5'd31, rs2: 5'd0, rd: 5'd0,  we: 1'b1, a: 32'h1000_001F, b: 32'h0,         busy: 32'h0000_0400};
        vt[3] = '{rs1: 5'd0,  rs2: 5'd0, rd: 5'd12, we: 1'b1, a: 32'h0,         b: 32'h0,         busy: 32'h0000_1400};
        vt[4] = '{rs1: 5'd6,  rs2: 5'd6, rd: 5'd13, we: 1'b1, a: 32'h1000_0006, b: 32'h1000_0006, busy: 32'h0000_3400};
        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        chk("rst_opnd_valid", {31'b0, opnd_valid}, 32'd0);
        chk("rst_wr_en", {31'b0, rf_write_en}, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_opnd_a", opnd_a, 32'd0);
        chk("rst_wb1_ready", {31'b0, wb1_ready}, 32'd1);
        rst = 0;
        @(negedge clk);
        chk("wb_single_ready", {31'b0, wb0_ready}, 32'd1);
        wb0_push(5'd5, 32'hDEAD_BEEF);
        chk("wb_single_en", {31'b0, rf_write_en}, 32'd1);
        chk("wb_single_dest", {27'b0, rf_write_dest}, 32'd5);
        chk("wb_single_data", rf_write_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wb_single_done", {31'b0, rf_write_en}, 32'd0);
        wb0_push(5'd0, 32'h55);
        chk("wb_x0_discard", {31'b0, rf_write_en}, 32'd0);
        issue(5'd0, 5'd3, 5'd4, 1'b1);
        chk("basic_lat", {31'b0, opnd_valid}, 32'd0);
        chk("basic_raddr2", {27'b0, rf_read_addr_2}, 32'd3);
        @(negedge clk);
        chk("basic_valid", {31'b0, opnd_valid}, 32'd1);
        chk("basic_a", opnd_a, 32'd0);
        chk("basic_b", opnd_b, 32'h22);
        chk("basic_rd", {27'b0, opnd_rd}, 32'd4);
        chk("basic_busy", busy_mask, 32'h10);
        complete();
        wb0_push(5'd4, 32'h44);
        @(negedge clk);
        chk("basic_clear", busy_mask, 32'd0);
        for (int i = 0; i < 5; i++) begin
            issue(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].we);
            chk("vec_lat", {31'b0, opnd_valid}, 32'd0);
            chk("vec_raddr1", {27'b0, rf_read_addr_1}, {27'b0, vt[i].rs1});
            @(negedge clk);
            chk("vec_valid", {31'b0, opnd_valid}, 32'd1);
            chk("vec_a", opnd_a, vt[i].a);
            chk("vec_b", opnd_b, vt[i].b);
            chk("vec_rd", {27'b0, opnd_rd}, {27'b0, vt[i].rd});
            chk("vec_busy", busy_mask, vt[i].busy);
            complete();
        end
        wb0_valid = 1; wb0_rd = 5'd10; wb0_data = 32'hA0;
        wb1_valid = 1; wb1_rd = 5'd12; wb1_data = 32'hC0;
        chk("drain_r1", {31'b0, wb1_ready}, 32'd1);
        @(negedge clk);
        wb1_valid = 0; wb0_rd = 5'd13; wb0_data = 32'hD0;
        chk("drain_d0", {27'b0, rf_write_dest}, 32'd10);
        chk("drain_v0", rf_write_data, 32'hA0);
        @(negedge clk);
        wb0_valid = 0;
        chk("drain_d1", {27'b0, rf_write_dest}, 32'd12);
        chk("drain_v1", rf_write_data, 32'hC0);
        @(negedge clk);
        chk("drain_d2", {27'b0, rf_write_dest}, 32'd13);
        @(negedge clk);
        chk("drain_empty", {31'b0, rf_write_en}, 32'd0);
        chk("drain_busy", busy_mask, 32'd0);
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        @(negedge clk);
        complete();
        chk("raw_busy7", busy_mask, 32'h80);
        issue(5'd7, 5'd0, 5'd8, 1'b0);
        repeat (2) begin
            chk("raw_stall", {31'b0, opnd_valid}, 32'd0);
            @(negedge clk);
        end
        wb0_push(5'd7, 32'h1234);
        chk("raw_wr_dest", {27'b0, rf_write_dest}, 32'd7);
        chk("raw_still", {31'b0, opnd_valid}, 32'd0);
        @(negedge clk);
        chk("raw_cleared", busy_mask, 32'd0);
        chk("raw_not_yet", {31'b0, opnd_valid}, 32'd0);
        @(negedge clk);
        chk("raw_valid", {31'b0, opnd_valid}, 32'd1);
        chk("raw_a", opnd_a, 32'h1234);
        complete();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        @(negedge clk);
        complete();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        chk("waw_stall0", {31'b0, opnd_valid}, 32'd0);
        @(negedge clk);
        chk("waw_stall1", {31'b0, opnd_valid}, 32'd0);
        chk("waw_busy", busy_mask, 32'h200);
        wb0_push(5'd9, 32'h99);
        chk("waw_wr_dest", {27'b0, rf_write_dest}, 32'd9);
        chk("waw_hold", {31'b0, opnd_valid}, 32'd0);
        @(negedge clk);
        chk("waw_cleared", busy_mask, 32'd0);
        @(negedge clk);
        chk("waw_valid", {31'b0, opnd_valid}, 32'd1);
        chk("waw_reset_bit", busy_mask, 32'h200);
        chk("waw_rd", {27'b0, opnd_rd}, 32'd9);
        complete();
        for (int c = 0; c < 3; c++) begin
            wb0_valid = 1; wb0_rd = 5'(20 + 2 * c); wb0_data = 32'(20 + 2 * c);
            wb1_valid = 1; wb1_rd = 5'(21 + 2 * c); wb1_data = 32'(21 + 2 * c);
            chk("full_r0", {31'b0, wb0_ready}, 32'd1);
            chk("full_r1", {31'b0, wb1_ready}, (c < 2) ? 32'd1 : 32'd0);
            if (c > 0) chk("full_order", {27'b0, rf_write_dest}, 32'(19 + c));
            @(negedge clk);
        end
        wb0_valid = 0; wb1_valid = 0;
        for (int c = 3; c < 6; c++) begin
            chk("full_order", {27'b0, rf_write_dest}, 32'(19 + c));
            chk("full_data", rf_write_data, 32'(19 + c));
            @(negedge clk);
        end
        chk("full_no_extra", {31'b0, rf_write_en}, 32'd0);
        issue(5'd0, 5'd0, 5'd15, 1'b1);
        @(negedge clk);
        wb0_valid = 1; wb0_rd = 5'd16; wb1_valid = 1; wb1_rd = 5'd17;
        @(negedge clk);
        wb0_rd = 5'd18; wb1_rd = 5'd19;
        @(negedge clk);
        wb0_valid = 0; wb1_valid = 0;
        chk("pre_rst_valid", {31'b0, opnd_valid}, 32'd1);
        chk("pre_rst_en", {31'b0, rf_write_en}, 32'd1);
        chk("pre_rst_busy", busy_mask, 32'h8200);
        #1 rst = 1;
        #1;
        chk("rst_out_valid", {31'b0, opnd_valid}, 32'd0);
        chk("rst_out_en", {31'b0, rf_write_en}, 32'd0);
        chk("rst_out_busy", busy_mask, 32'd0);
        @(negedge clk);
        rst = 0;
        chk("post_rst_ready", {31'b0, issue_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_wr", {31'b0, rf_write_en}, 32'd0);
        end
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end
endmodule
